// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: widths, opcodes and the
// combinational core's result payload.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 4'h0;
    localparam logic [OP_W-1:0] ALU_ADDU  = 4'h1;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'h2;
    localparam logic [OP_W-1:0] ALU_SUBU  = 4'h3;
    localparam logic [OP_W-1:0] ALU_AND   = 4'h4;
    localparam logic [OP_W-1:0] ALU_OR    = 4'h5;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'h6;
    localparam logic [OP_W-1:0] ALU_NOR   = 4'h7;
    localparam logic [OP_W-1:0] ALU_SLT   = 4'h8;
    localparam logic [OP_W-1:0] ALU_SLTU  = 4'h9;
    localparam logic [OP_W-1:0] ALU_SLL   = 4'hA;
    localparam logic [OP_W-1:0] ALU_SRL   = 4'hB;
    localparam logic [OP_W-1:0] ALU_SRA   = 4'hC;
    localparam logic [OP_W-1:0] ALU_MULT  = 4'hD;
    localparam logic [OP_W-1:0] ALU_MULTU = 4'hE;
    localparam logic [OP_W-1:0] ALU_LUI   = 4'hF;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              overflow;
        logic              hilo_we;
    } alu_out_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: opcode + operands -> result, HI/LO product,
// signed overflow and a flag telling the wrapper to update HI/LO.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output alu_out_t          o_res
);

    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_slt;
    logic               w_sltu;
    logic [SHAMT_W-1:0] w_sh;
    logic               w_mul_signed;
    logic [PROD_W-1:0]  w_a_ext;
    logic [PROD_W-1:0]  w_b_ext;
    logic [PROD_W-1:0]  w_prod;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Overflow only when operand signs make it possible and the result sign flips.
    assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1]  != i_a[DATA_W-1]);
    assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    assign w_slt  = $signed(i_a) < $signed(i_b);
    assign w_sltu = i_a < i_b;
    assign w_sh   = i_a[SHAMT_W-1:0];

    // One shared multiplier; sign- or zero-extension to 64 bits selects MULT vs MULTU.
    assign w_mul_signed = (i_op == ALU_MULT);
    assign w_a_ext = {{DATA_W{w_mul_signed & i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{DATA_W{w_mul_signed & i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        o_res = '0;
        unique case (i_op)
            ALU_ADD: begin
                o_res.result   = w_sum;
                o_res.overflow = w_add_ovf;
            end
            ALU_ADDU: o_res.result = w_sum;
            ALU_SUB: begin
                o_res.result   = w_diff;
                o_res.overflow = w_sub_ovf;
            end
            ALU_SUBU: o_res.result = w_diff;
            ALU_AND:  o_res.result = i_a & i_b;
            ALU_OR:   o_res.result = i_a | i_b;
            ALU_XOR:  o_res.result = i_a ^ i_b;
            ALU_NOR:  o_res.result = ~(i_a | i_b);
            ALU_SLT:  o_res.result = {{(DATA_W-1){1'b0}}, w_slt};
            ALU_SLTU: o_res.result = {{(DATA_W-1){1'b0}}, w_sltu};
            ALU_SLL:  o_res.result = i_b << w_sh;
            ALU_SRL:  o_res.result = i_b >> w_sh;
            ALU_SRA:  o_res.result = DATA_W'($signed(i_b) >>> w_sh);
            ALU_MULT, ALU_MULTU: begin
                o_res.result  = w_prod[DATA_W-1:0];
                o_res.hi      = w_prod[PROD_W-1:DATA_W];
                o_res.lo      = w_prod[DATA_W-1:0];
                o_res.hilo_we = 1'b1;
            end
            ALU_LUI:  o_res.result = {i_b[15:0], 16'h0000};
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage slice: operand-A mux, registered ALU/HI/LO/flags captured on
// alu_en, and the branch next-PC register captured on branch_en.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_en,
    input  logic [OP_W-1:0]    alu_control,
    input  logic [DATA_W-1:0]  read_data1,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               select_shamt,
    input  logic [DATA_W-1:0]  alu_srcB,
    input  logic               branch_en,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  pc,
    output logic [DATA_W-1:0]  alu_srcA,
    output logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo,
    output logic               overflow,
    output logic               alu_zero,
    output logic [DATA_W-1:0]  pc_out
);

    alu_out_t          w_core;
    logic [DATA_W-1:0] w_branch_target;

    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_overflow;
    logic              r_alu_zero;
    logic [DATA_W-1:0] r_pc_out;

    // Zero-latency operand A, deliberately outside the reset domain.
    assign alu_srcA = select_shamt ? {{(DATA_W-SHAMT_W){1'b0}}, shamt} : read_data1;

    alu_core u_alu_core (
        .i_op  (alu_control),
        .i_a   (alu_srcA),
        .i_b   (alu_srcB),
        .o_res (w_core)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_result <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_overflow   <= 1'b0;
            r_alu_zero   <= 1'b0;
        end else if (alu_en) begin
            r_alu_result <= w_core.result;
            r_overflow   <= w_core.overflow;
            r_alu_zero   <= (w_core.result == '0);
            if (w_core.hilo_we) begin
                r_hi <= w_core.hi;
                r_lo <= w_core.lo;
            end
        end
    end

    // Branch decision uses the registered zero flag, i.e. the pre-edge value.
    assign w_branch_target = pc + imm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_out <= '0;
        end else if (branch_en) begin
            r_pc_out <= r_alu_zero ? w_branch_target : pc;
        end
    end

    assign alu_result = r_alu_result;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign overflow   = r_overflow;
    assign alu_zero   = r_alu_zero;
    assign pc_out     = r_pc_out;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an expected-result queue.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    logic [31:0] alu_srcB;
    logic        branch_en;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_srcA;
    logic [31:0] alu_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;
    logic        alu_zero;
    logic [31:0] pc_out;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .alu_en       (alu_en),
        .alu_control  (alu_control),
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .alu_srcB     (alu_srcB),
        .branch_en    (branch_en),
        .imm          (imm),
        .pc           (pc),
        .alu_srcA     (alu_srcA),
        .alu_result   (alu_result),
        .hi           (hi),
        .lo           (lo),
        .overflow     (overflow),
        .alu_zero     (alu_zero),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare every registered ALU output.
    task automatic check_out();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_result"}, alu_result, e.result);
            chk({e.tag, "_hi"},     hi,         e.hi);
            chk({e.tag, "_lo"},     lo,         e.lo);
            chk({e.tag, "_ovf"},    {31'b0, overflow}, {31'b0, e.ovf});
            chk({e.tag, "_zero"},   {31'b0, alu_zero}, {31'b0, e.zero});
        end
    endtask

    task automatic do_alu(input string tag, input logic [3:0] op, input logic sel,
                          input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [31:0] h, input logic [31:0] l,
                          input logic v, input logic z);
        exp_t e;
        @(negedge clk);
        alu_control  = op;
        select_shamt = sel;
        shamt        = sa;
        read_data1   = a;
        alu_srcB     = b;
        alu_en       = 1'b1;
        e = '{tag, r, h, l, v, z};
        sb.push_back(e);
        @(posedge clk);
        #1;
        alu_en = 1'b0;
        check_out();
    endtask

    task automatic do_branch(input string tag, input logic [31:0] p, input logic [31:0] i,
                             input logic [31:0] exp_pc);
        @(negedge clk);
        pc        = p;
        imm       = i;
        branch_en = 1'b1;
        @(posedge clk);
        #1;
        branch_en = 1'b0;
        chk(tag, pc_out, exp_pc);
    endtask

    initial begin
        reset = 1'b1; alu_en = 1'b1; alu_control = ALU_ADD;
        read_data1 = 32'd5; alu_srcB = 32'd1; shamt = 5'd0; select_shamt = 1'b0;
        branch_en = 1'b1; pc = 32'h10; imm = 32'h4;

        // Reset wins over both enables; operand A mux ignores reset.
        @(posedge clk); #1;
        chk("rst_srcA", alu_srcA, 32'd5);
        sb.push_back('{"rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        check_out();
        chk("rst_pc", pc_out, 32'h0);

        @(negedge clk);
        reset = 1'b0; alu_en = 1'b0; branch_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{"idle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        check_out();
        chk("idle_pc", pc_out, 32'h0);

        do_alu("add_ovf",  ALU_ADD,  0, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0);
        do_alu("addu",     ALU_ADDU, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0);
        do_alu("add_neg",  ALU_ADD,  0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0);
        do_alu("sub_zero", ALU_SUB,  0, 0, 32'd5, 32'd5, 32'h0, 0, 0, 0, 1);
        do_branch("br_taken", 32'h10, 32'hFFFFFFFC, 32'h0C);
        do_alu("sub_nz",   ALU_SUB,  0, 0, 32'd5, 32'd3, 32'h2, 0, 0, 0, 0);
        do_branch("br_not", 32'h10, 32'hFFFFFFFC, 32'h10);
        do_alu("sub_ovf",  ALU_SUB,  0, 0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1, 0);

        @(negedge clk);
        select_shamt = 1'b1; shamt = 5'd4; #1;
        chk("srcA_shamt", alu_srcA, 32'h4);
        do_alu("sll", ALU_SLL, 1, 5'd4,  32'hDEADBEEF, 32'h1, 32'h10, 0, 0, 0, 0);
        do_alu("sra", ALU_SRA, 1, 5'd31, 32'hDEADBEEF, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        do_alu("srl", ALU_SRL, 1, 5'd31, 32'hDEADBEEF, 32'h80000000, 32'h1, 0, 0, 0, 0);

        do_alu("mult",  ALU_MULT,  0, 0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        do_alu("and",   ALU_AND,   0, 0, 32'hFFFFFFFE, 32'd3, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        do_alu("multu", ALU_MULTU, 0, 0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 0, 0);
        do_alu("nor",   ALU_NOR,   0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0);
        do_alu("xor",   ALU_XOR,   0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h1, 32'hFFFFFFFE, 0, 0);
        do_alu("slt",   ALU_SLT,   0, 0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFE, 0, 0);
        do_alu("sltu",  ALU_SLTU,  0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 32'hFFFFFFFE, 0, 1);
        do_alu("lui",   ALU_LUI,   0, 0, 32'h0, 32'h1234, 32'h12340000, 32'h1, 32'hFFFFFFFE, 0, 0);

        // Operands change with alu_en low: everything must hold.
        @(negedge clk);
        alu_control = ALU_MULT; read_data1 = 32'd7; alu_srcB = 32'd9; alu_en = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{"hold", 32'h12340000, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0});
        check_out();

        // Same-edge ALU and branch: branch sees the old (0) zero flag.
        @(negedge clk);
        alu_control = ALU_SUB; select_shamt = 1'b0; read_data1 = 32'd7; alu_srcB = 32'd7;
        alu_en = 1'b1; branch_en = 1'b1; pc = 32'h100; imm = 32'h20;
        sb.push_back('{"both", 32'h0, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b1});
        @(posedge clk); #1;
        alu_en = 1'b0; branch_en = 1'b0;
        check_out();
        chk("both_pc", pc_out, 32'h100);
        do_branch("br_after_both", 32'h100, 32'h20, 32'h120);

        // Mid-run reset clears HI/LO and PC as well.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back('{"rst2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        check_out();
        chk("rst2_pc", pc_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage datapath slice of the multi-cycle MIPS core: selects ALU operand A (register or shift amount), performs the 4-bit-coded ALU operation with HI/LO multiply results, and computes the branch next-PC from the ALU zero flag. All results are registered on enable strobes issued by the control FSM (EXECUTE / BRANCH states) and held between strobes.

## Interface
No parameters; data width fixed at 32 bits.
- clk  in  1  system clock (the slow core clock)
- reset  in  1  synchronous, active-high; clears all registered outputs
- alu_en  in  1  capture ALU result on this edge
- alu_control  in  4  ALU operation code (see Operation)
- read_data1  in  32  register rs value
- shamt  in  5  instruction shift amount
- select_shamt  in  1  1: operand A = zero-extended shamt; 0: read_data1
- alu_srcB  in  32  operand B (rt or extended immediate, muxed upstream)
- branch_en  in  1  capture branch next-PC on this edge
- imm  in  32  sign-extended branch offset (words)
- pc  in  32  current PC (word address, already incremented)
- alu_srcA  out  32  combinational operand-A mux output
- alu_result  out  32  registered result
- hi  out  32  registered upper multiply product
- lo  out  32  registered lower multiply product
- overflow  out  1  registered signed overflow flag
- alu_zero  out  1  registered, 1 when alu_result == 0
- pc_out  out  32  registered branch next-PC

## Operation
- alu_srcA = select_shamt ? {27'b0, shamt} : read_data1 (combinational, no enable).
- Opcodes (A = alu_srcA, B = alu_srcB): 0 ADD (signed, overflow), 1 ADDU, 2 SUB A−B (signed, overflow), 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed, result 1/0), 9 SLTU, A SLL B<<A[4:0], B SRL B>>A[4:0] logical, C SRA B>>>A[4:0] arithmetic, D MULT signed 64-bit, E MULTU, F LUI {B[15:0],16'b0}.
- Overflow: ADD set when A,B same sign and result sign differs; SUB set when A,B signs differ and result sign differs from A. All other opcodes clear overflow. Result is the wrapped 32-bit value regardless (no trap).
- MULT/MULTU: {hi,lo} <= 64-bit product; alu_result <= low 32 bits. All other opcodes leave hi/lo unchanged.
- alu_zero derived from the newly computed result, captured in the same edge.
- Branch: pc_out <= alu_zero ? pc + imm : pc (32-bit wrap-around add, uses registered alu_zero).

## Timing
- Reset (sync, highest priority): alu_result, hi, lo, pc_out = 0; overflow = 0; alu_zero = 0 (not 1).
- ALU latency: 1 edge — operands stable at edge with alu_en=1 → outputs valid after that edge. alu_en=0: all ALU outputs hold.
- Branch latency: 1 edge with branch_en=1; branch_en=0: pc_out holds.
- alu_en and branch_en in the same edge: branch uses pre-edge alu_zero (old value); both registers update.
- No handshake; control FSM guarantees operands stable for the enabled edge.
- alu_srcA has zero latency and is independent of reset.

## Structure
- Shared package alu_pkg: 4-bit opcode localparams (ALU_ADD … ALU_LUI), data width constant 32.
- One natural sub-module: alu_core (purely combinational opcode → result/hi/lo/overflow, valid-hi/lo flag); top wraps mux, registers, branch adder.

## Test plan
- Reset asserted with alu_en=1 → all outputs 0, alu_zero=0; release, no enable → outputs hold 0.
- ADD 0x7FFFFFFF + 1, alu_en one edge → alu_result 0x80000000, overflow 1, zero 0; ADDU same → overflow 0.
- SUB 5−5 then branch_en next edge with pc=0x10, imm=0xFFFFFFFC → alu_zero 1, pc_out 0x0C; SUB 5−3 then branch → pc_out 0x10.
- select_shamt=1, shamt=4, SLL B=0x1 → alu_srcA 0x4, result 0x10; SRA B=0x80000000, shamt=31 → 0xFFFFFFFF; SRL → 0x1.
- MULT A=−2 (0xFFFFFFFE), B=3 → hi 0xFFFFFFFF, lo 0xFFFFFFFA; then AND op → hi/lo unchanged; MULTU 0xFFFFFFFF×2 → hi 1, lo 0xFFFFFFFE.
- SLT −1 vs 1 → 1, SLTU → 0; LUI B=0x1234 → 0x12340000; alu_en=0 with changing operands → result stable.
